// File: rtl/frame_sequencer_consumer_if.sv
// Signal bundle between the frame divider / register front end (master) and
// the per-channel frame-sequencer consumer (slave).
interface frame_sequencer_consumer_if #(
  parameter int LEN_WIDTH = 6
) ();
  logic                 clock_256;
  logic                 clock_64;
  logic                 trigger;
  logic                 length_write;
  logic [LEN_WIDTH-1:0] length_load;
  logic                 length_enable;
  logic [3:0]           env_initial;
  logic                 env_dir;
  logic [2:0]           env_period;
  logic                 channel_on;
  logic [3:0]           volume;
  logic [LEN_WIDTH:0]   length_count;

  modport master (
    output clock_256, clock_64, trigger, length_write, length_load,
           length_enable, env_initial, env_dir, env_period,
    input  channel_on, volume, length_count
  );

  modport slave (
    input  clock_256, clock_64, trigger, length_write, length_load,
           length_enable, env_initial, env_dir, env_period,
    output channel_on, volume, length_count
  );
endinterface

// File: rtl/frame_sequencer_consumer.sv
// Per-channel length counter and volume envelope driven by 256 Hz / 64 Hz frame ticks.
// Optional macro FRAME_SEQ_SYNC_EN adds 2-flop synchronizers on the slow inputs.
//
// state     | meaning
// ST_IDLE   | after reset, no trigger seen yet; volume held
// ST_RUN    | envelope stepping on 64 Hz ticks
// ST_HOLD   | envelope frozen (period 0 or volume saturated) until next trigger
module frame_sequencer_consumer #(
  parameter int LEN_WIDTH = 6
) (
  input logic                      clock,
  input logic                      reset,
  frame_sequencer_consumer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} env_state_t;

  localparam logic [LEN_WIDTH:0] LEN_FULL = {1'b1, {LEN_WIDTH{1'b0}}};

  logic src256, src64;
  logic smp256_q, prv256_q, smp64_q, prv64_q;
  logic tick256, tick64;

`ifdef FRAME_SEQ_SYNC_EN
  logic [1:0] sync256_q, sync64_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync256_q <= 2'b00;
      sync64_q  <= 2'b00;
    end else begin
      sync256_q <= {sync256_q[0], bus.clock_256};
      sync64_q  <= {sync64_q[0], bus.clock_64};
    end
  end

  assign src256 = sync256_q[1];
  assign src64  = sync64_q[1];
`else
  assign src256 = bus.clock_256;
  assign src64  = bus.clock_64;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      smp256_q <= 1'b0;
      prv256_q <= 1'b0;
      smp64_q  <= 1'b0;
      prv64_q  <= 1'b0;
    end else begin
      smp256_q <= src256;
      prv256_q <= smp256_q;
      smp64_q  <= src64;
      prv64_q  <= smp64_q;
    end
  end

  assign tick256 = smp256_q & ~prv256_q;
  assign tick64  = smp64_q & ~prv64_q;

  // Length counter and channel enable
  logic [LEN_WIDTH:0] len_q, len_d;
  logic               chon_q, chon_d;
  logic               dac_en;

  assign dac_en = (bus.env_initial != 4'd0) | bus.env_dir;

  always_comb begin
    len_d  = len_q;
    chon_d = chon_q;
    if (bus.length_write) begin
      len_d = LEN_FULL - {1'b0, bus.length_load};
    end else if (bus.trigger) begin
      if (len_q == '0) len_d = LEN_FULL;
    end else if (tick256 && bus.length_enable && len_q != '0) begin
      len_d = len_q - 1'b1;
      if (len_q == {{LEN_WIDTH{1'b0}}, 1'b1}) chon_d = 1'b0;
    end
    if (bus.trigger) chon_d = dac_en;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q  <= '0;
      chon_q <= 1'b0;
    end else begin
      len_q  <= len_d;
      chon_q <= chon_d;
    end
  end

  // Envelope FSM
  env_state_t state_q, state_d;
  logic [3:0] vol_q, vol_d;
  logic [2:0] timer_q, timer_d;
  logic       at_limit;
  logic       reload;

  assign at_limit = bus.env_dir ? (vol_q == 4'd15) : (vol_q == 4'd0);
  assign reload   = (state_q == ST_RUN) && tick64 && (timer_q <= 3'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vol_q   <= 4'd0;
      timer_q <= 3'd0;
    end else begin
      state_q <= state_d;
      vol_q   <= vol_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.trigger) begin
      state_d = (bus.env_period != 3'd0) ? ST_RUN : ST_HOLD;
    end else if (reload && (at_limit || bus.env_period == 3'd0)) begin
      state_d = ST_HOLD;
    end
  end

  always_comb begin
    vol_d   = vol_q;
    timer_d = timer_q;
    if (bus.trigger) begin
      vol_d   = bus.env_initial;
      timer_d = bus.env_period;
    end else if (state_q == ST_RUN && tick64) begin
      if (timer_q > 3'd1) begin
        timer_d = timer_q - 3'd1;
      end else begin
        timer_d = bus.env_period;
        if (!at_limit) vol_d = bus.env_dir ? vol_q + 4'd1 : vol_q - 4'd1;
      end
    end
  end

  assign bus.channel_on   = chon_q;
  assign bus.volume       = vol_q;
  assign bus.length_count = len_q;

endmodule

// File: tb/tb_frame_sequencer_consumer.sv
// Directed bench for frame_sequencer_consumer (LEN_WIDTH=6, default build, 2-cycle tick latency).
module tb_frame_sequencer_consumer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  frame_sequencer_consumer_if #(.LEN_WIDTH(6)) bus ();

  frame_sequencer_consumer #(.LEN_WIDTH(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_trigger();
    bus.trigger = 1'b1;
    step(1);
    bus.trigger = 1'b0;
  endtask

  task automatic edge256();
    bus.clock_256 = 1'b1;
    step(2);
    bus.clock_256 = 1'b0;
    step(2);
  endtask

  task automatic edge64();
    bus.clock_64 = 1'b1;
    step(2);
    bus.clock_64 = 1'b0;
    step(2);
  endtask

  task automatic set_env(input int init, input int dir, input int period);
    bus.env_initial = 4'(init);
    bus.env_dir     = 1'(dir);
    bus.env_period  = 3'(period);
  endtask

  int exp_dec [8] = '{3, 2, 2, 1, 1, 0, 0, 0};
  int exp_len [3] = '{2, 1, 0};

  initial begin
    // reset with all inputs active
    bus.clock_256 = 1'b1; bus.clock_64 = 1'b1; bus.trigger = 1'b1;
    bus.length_write = 1'b1; bus.length_load = 6'd5; bus.length_enable = 1'b1;
    set_env(8, 1, 1);
    step(2);
    chk("rst_chon", bus.channel_on, 0);
    chk("rst_vol", bus.volume, 0);
    chk("rst_len", bus.length_count, 0);

    bus.clock_256 = 1'b0; bus.clock_64 = 1'b0; bus.trigger = 1'b0;
    bus.length_write = 1'b0; bus.length_enable = 1'b0;
    reset = 1'b0;
    step(3);

    // length load 60 -> 4, no decrement while clock_256 is low
    bus.length_load = 6'd60;
    bus.length_write = 1'b1;
    step(1);
    bus.length_write = 1'b0;
    bus.length_enable = 1'b1;
    step(4);
    chk("len_load60", bus.length_count, 4);

    set_env(8, 0, 0);
    pulse_trigger();
    chk("trig_chon", bus.channel_on, 1);
    chk("trig_vol8", bus.volume, 8);
    chk("trig_len_keep", bus.length_count, 4);

    // first edge: effect exactly 2 cycles after input edge
    bus.clock_256 = 1'b1;
    step(1);
    chk("len_lat1", bus.length_count, 4);
    step(1);
    chk("len_lat2", bus.length_count, 3);
    bus.clock_256 = 1'b0;
    step(2);

    for (int i = 0; i < 2; i++) begin
      edge256();
      chk($sformatf("len_edge%0d", i + 2), bus.length_count, exp_len[i]);
    end
    chk("chon_before_expiry", bus.channel_on, 1);

    bus.clock_256 = 1'b1;
    step(1);
    chk("chon_exp_lat1", bus.channel_on, 1);
    step(1);
    chk("chon_expired", bus.channel_on, 0);
    chk("len_zero", bus.length_count, exp_len[2]);
    bus.clock_256 = 1'b0;
    step(2);
    edge256();
    chk("len_no_wrap", bus.length_count, 0);

    // envelope decrease; trigger also reloads empty length counter
    set_env(3, 0, 2);
    pulse_trigger();
    chk("trig_len64", bus.length_count, 64);
    chk("dec_vol0", bus.volume, 3);
    chk("dec_chon", bus.channel_on, 1);
    for (int i = 0; i < 8; i++) begin
      edge64();
      chk($sformatf("dec_edge%0d", i + 1), bus.volume, exp_dec[i]);
    end

    // saturation up
    set_env(14, 1, 1);
    pulse_trigger();
    chk("sat_vol0", bus.volume, 14);
    for (int i = 0; i < 3; i++) begin
      edge64();
      chk($sformatf("sat_edge%0d", i + 1), bus.volume, 15);
    end

    // trigger coincident with tick64: no step that cycle
    set_env(5, 1, 1);
    pulse_trigger();
    bus.clock_64 = 1'b1;
    step(1);
    pulse_trigger();
    chk("prio64_vol", bus.volume, 5);
    bus.clock_64 = 1'b0;
    step(2);
    edge64();
    chk("prio64_next", bus.volume, 6);

    // trigger coincident with tick256: no decrement
    bus.clock_256 = 1'b1;
    step(1);
    pulse_trigger();
    chk("prio256_trig", bus.length_count, 64);
    bus.clock_256 = 1'b0;
    step(2);
    edge256();
    chk("len_63", bus.length_count, 63);

    // length_write coincident with tick256: write wins
    bus.clock_256 = 1'b1;
    step(1);
    bus.length_load = 6'd10;
    bus.length_write = 1'b1;
    step(1);
    bus.length_write = 1'b0;
    chk("prio256_write", bus.length_count, 54);
    bus.clock_256 = 1'b0;
    step(2);

    // DAC off / on
    set_env(0, 0, 3);
    pulse_trigger();
    chk("dac_off_chon", bus.channel_on, 0);
    chk("dac_off_vol", bus.volume, 0);
    set_env(0, 1, 3);
    pulse_trigger();
    chk("dac_on_up_chon", bus.channel_on, 1);

    // async reset mid-RUN
    set_env(9, 0, 3);
    pulse_trigger();
    chk("pre_rst_vol", bus.volume, 9);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_chon", bus.channel_on, 0);
    chk("arst_vol", bus.volume, 0);
    chk("arst_len", bus.length_count, 0);
    step(1);
    reset = 1'b0;
    bus.length_load = 6'd0;
    bus.length_write = 1'b1;
    step(1);
    bus.length_write = 1'b0;
    step(4);
    chk("post_rst_len", bus.length_count, 64);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
